// File: rtl/line_buffer_scheduler_pkg.sv
// Shared types and constants for the line buffer scheduler.
package line_buffer_scheduler_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILL   = 2'd1,
      STREAM = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam int unsigned RD_LAT = 1;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/line_buffer_scheduler_if.sv
// Pixel handshake plus row-buffer / window-mux control bundle.
interface line_buffer_scheduler_if #(
   parameter int unsigned LINE_LEN = 256,
   parameter int unsigned NUM_ROWS = 256,
   parameter int unsigned NUM_BUF  = 3
) ();
   import line_buffer_scheduler_pkg::*;

   localparam int unsigned CW = idx_width(LINE_LEN);
   localparam int unsigned RW = idx_width(NUM_ROWS);
   localparam int unsigned BW = idx_width(NUM_BUF);

   logic          start;
   logic          pixValid;
   logic          pixReady;
   logic          wrEn;
   logic [BW-1:0] wrBuf;
   logic [CW-1:0] wrAddr;
   logic          rdEn;
   logic [CW-1:0] rdAddr;
   logic [BW-1:0] topSel;
   logic [BW-1:0] midSel;
   logic          winValid;
   logic [CW-1:0] winCol;
   logic [RW-1:0] winRow;
   logic          busy;
   logic          frameDone;

   modport master (
      output start, pixValid,
      input  pixReady, wrEn, wrBuf, wrAddr, rdEn, rdAddr, topSel, midSel,
             winValid, winCol, winRow, busy, frameDone
   );

   modport slave (
      input  start, pixValid,
      output pixReady, wrEn, wrBuf, wrAddr, rdEn, rdAddr, topSel, midSel,
             winValid, winCol, winRow, busy, frameDone
   );

endinterface

// File: rtl/line_buffer_scheduler_mod_counter.sv
// Wrap-around counter 0..MOD-1 with synchronous clear, enable and terminal count.
module mod_counter
   import line_buffer_scheduler_pkg::*;
#(
   parameter int unsigned MOD   = 4,
   parameter int unsigned WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   output logic [WIDTH-1:0] count,
   output logic             tc
);

   typedef logic [WIDTH-1:0] cnt_t;

   assign tc = (count == cnt_t'(MOD - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= tc ? '0 : count + cnt_t'(1);
      end
   end

endmodule

// File: rtl/line_buffer_scheduler.sv
// Rotating row-buffer scheduler: write addressing for the live row and
// read/select control for the two stored rows of a 3x3 window.
module line_buffer_scheduler
   import line_buffer_scheduler_pkg::*;
#(
   parameter int unsigned LINE_LEN = 256,
   parameter int unsigned NUM_ROWS = 256,
   parameter int unsigned NUM_BUF  = 3
) (
   input  logic                  mainClk,
   input  logic                  reset,
   line_buffer_scheduler_if.slave bus
);

   localparam int unsigned CW = idx_width(LINE_LEN);
   localparam int unsigned RW = idx_width(NUM_ROWS);
   localparam int unsigned BW = idx_width(NUM_BUF);

   typedef logic [CW-1:0] col_t;
   typedef logic [RW-1:0] row_t;
   typedef logic [BW-1:0] buf_t;
   typedef logic [BW:0]   bsum_t;

   state_t state, state_next;
   logic   active, accept, restart, row_adv;
   col_t   col;
   row_t   row;
   buf_t   wbuf, top_sel, mid_sel;
   logic   col_tc, row_tc;
   bsum_t  top_sum, mid_sum;

   assign active  = (state == FILL) || (state == STREAM);
   assign accept  = active && bus.pixValid;
   assign restart = bus.start && ((state == IDLE) || (state == DONE));
   assign row_adv = accept && col_tc;

   mod_counter #(.MOD(LINE_LEN), .WIDTH(CW)) u_col (
      .clk(mainClk), .rst(reset), .clr(restart), .en(accept),
      .count(col), .tc(col_tc)
   );

   mod_counter #(.MOD(NUM_ROWS), .WIDTH(RW)) u_row (
      .clk(mainClk), .rst(reset), .clr(restart), .en(row_adv),
      .count(row), .tc(row_tc)
   );

   mod_counter #(.MOD(NUM_BUF), .WIDTH(BW)) u_buf (
      .clk(mainClk), .rst(reset), .clr(restart), .en(row_adv),
      .count(wbuf), .tc()
   );

   // Older rows sit one and two buffers behind the writer, modulo NUM_BUF.
   assign top_sum = {1'b0, wbuf} + bsum_t'(NUM_BUF - 2);
   assign mid_sum = {1'b0, wbuf} + bsum_t'(NUM_BUF - 1);
   assign top_sel = (top_sum >= bsum_t'(NUM_BUF)) ? buf_t'(top_sum - bsum_t'(NUM_BUF))
                                                  : buf_t'(top_sum);
   assign mid_sel = (mid_sum >= bsum_t'(NUM_BUF)) ? buf_t'(mid_sum - bsum_t'(NUM_BUF))
                                                  : buf_t'(mid_sum);

   always_ff @(posedge mainClk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bus.start) state_next = FILL;
         FILL:    if (row_adv && (row == row_t'(1))) state_next = STREAM;
         STREAM:  if (row_adv && row_tc) state_next = DONE;
         DONE:    if (bus.start) state_next = FILL;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      bus.pixReady  = active;
      bus.busy      = active;
      bus.frameDone = (state == DONE);
      bus.wrEn      = accept;
      bus.wrBuf     = wbuf;
      bus.wrAddr    = '0;
      bus.rdEn      = 1'b0;
      bus.rdAddr    = '0;
      bus.topSel    = '0;
      bus.midSel    = '0;
      if (accept) begin
         bus.wrAddr = col;
      end
      if (accept && (state == STREAM)) begin
         bus.rdEn   = 1'b1;
         bus.rdAddr = col;
         bus.topSel = top_sel;
         bus.midSel = mid_sel;
      end
   end

   // Window tags track the RAM read pipeline so they line up with mux data.
   logic vld_q [RD_LAT];
   col_t col_q [RD_LAT];
   row_t row_q [RD_LAT];

   always_ff @(posedge mainClk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < RD_LAT; i++) begin
            vld_q[i] <= 1'b0;
            col_q[i] <= '0;
            row_q[i] <= '0;
         end
      end else begin
         vld_q[0] <= bus.rdEn;
         col_q[0] <= bus.rdAddr;
         row_q[0] <= row - row_t'(2);
         for (int unsigned i = 1; i < RD_LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
            col_q[i] <= col_q[i-1];
            row_q[i] <= row_q[i-1];
         end
      end
   end

   assign bus.winValid = vld_q[RD_LAT-1];
   assign bus.winCol   = col_q[RD_LAT-1];
   assign bus.winRow   = row_q[RD_LAT-1];

endmodule

// File: tb/tb_line_buffer_scheduler.sv
// Bench for line_buffer_scheduler: directed vector table plus random traffic
// checked against an accept-count model of the frame.
module tb_line_buffer_scheduler;
   import line_buffer_scheduler_pkg::*;

   localparam int unsigned L     = 4;
   localparam int unsigned R     = 5;
   localparam int unsigned NB    = 3;
   localparam int unsigned TOTAL = L * R;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   line_buffer_scheduler_if #(.LINE_LEN(L), .NUM_ROWS(R), .NUM_BUF(NB)) bus ();

   line_buffer_scheduler #(.LINE_LEN(L), .NUM_ROWS(R), .NUM_BUF(NB)) dut (
      .mainClk(clk),
      .reset  (rst),
      .bus    (bus)
   );

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, ".pixReady"},  bus.pixReady,  0);
      chk({tag, ".wrEn"},      bus.wrEn,      0);
      chk({tag, ".rdEn"},      bus.rdEn,      0);
      chk({tag, ".winValid"},  bus.winValid,  0);
      chk({tag, ".busy"},      bus.busy,      0);
      chk({tag, ".frameDone"}, bus.frameDone, 0);
      chk({tag, ".wrBuf"},     bus.wrBuf,     0);
      chk({tag, ".wrAddr"},    bus.wrAddr,    0);
      chk({tag, ".rdAddr"},    bus.rdAddr,    0);
      chk({tag, ".topSel"},    bus.topSel,    0);
      chk({tag, ".midSel"},    bus.midSel,    0);
      chk({tag, ".winCol"},    bus.winCol,    0);
      chk({tag, ".winRow"},    bus.winRow,    0);
   endtask

   // Reference model: frame phase (0 idle, 1 running, 2 done) and accepts so far.
   int          m_phase;
   int unsigned m_k;
   logic        m_wv;
   int unsigned m_wcol, m_wrow;

   task automatic model_reset();
      m_phase = 0;
      m_k     = 0;
      m_wv    = 1'b0;
      m_wcol  = 0;
      m_wrow  = 0;
   endtask

   task automatic cycle(input logic st, input logic pv);
      int unsigned row, col;
      logic running, acc, rd;
      @(negedge clk);
      bus.start    = st;
      bus.pixValid = pv;
      #1;
      row     = m_k / L;
      col     = m_k % L;
      running = (m_phase == 1);
      acc     = running && pv;
      rd      = acc && (row >= 2);
      chk("pixReady",  bus.pixReady,  running);
      chk("busy",      bus.busy,      running);
      chk("frameDone", bus.frameDone, m_phase == 2);
      chk("wrEn",      bus.wrEn,      acc);
      chk("wrBuf",     bus.wrBuf,     row % NB);
      chk("rdEn",      bus.rdEn,      rd);
      chk("winValid",  bus.winValid,  m_wv);
      if (acc) chk("wrAddr", bus.wrAddr, col);
      if (rd) begin
         chk("rdAddr", bus.rdAddr, col);
         chk("topSel", bus.topSel, (row - 2) % NB);
         chk("midSel", bus.midSel, (row - 1) % NB);
      end
      if (m_wv) begin
         chk("winCol", bus.winCol, m_wcol);
         chk("winRow", bus.winRow, m_wrow);
      end
      m_wv   = rd;
      m_wcol = col;
      m_wrow = rd ? row - 2 : 0;
      if ((m_phase != 1) && st) begin
         m_phase = 1;
         m_k     = 0;
      end else if (acc) begin
         m_k++;
         if (m_k == TOTAL) m_phase = 2;
      end
   endtask

   typedef struct {
      logic        st, pv;
      logic        rdy, wen;
      int unsigned wbuf, waddr;
      logic        ren;
      int unsigned raddr, top, mid;
      logic        wv;
      int unsigned wcol, wrow;
      logic        busy, done;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic st, pv, rdy, wen, input int unsigned wbuf, waddr,
                      input logic ren, input int unsigned raddr, top, mid,
                      input logic wv, input int unsigned wcol, wrow,
                      input logic busy, done);
      vec_t v;
      v.st = st; v.pv = pv; v.rdy = rdy; v.wen = wen; v.wbuf = wbuf; v.waddr = waddr;
      v.ren = ren; v.raddr = raddr; v.top = top; v.mid = mid;
      v.wv = wv; v.wcol = wcol; v.wrow = wrow; v.busy = busy; v.done = done;
      tbl.push_back(v);
   endtask

   task automatic run_table();
      foreach (tbl[i]) begin
         @(negedge clk);
         bus.start    = tbl[i].st;
         bus.pixValid = tbl[i].pv;
         #1;
         chk($sformatf("t%0d.pixReady", i),  bus.pixReady,  tbl[i].rdy);
         chk($sformatf("t%0d.wrEn", i),      bus.wrEn,      tbl[i].wen);
         chk($sformatf("t%0d.wrBuf", i),     bus.wrBuf,     tbl[i].wbuf);
         chk($sformatf("t%0d.rdEn", i),      bus.rdEn,      tbl[i].ren);
         chk($sformatf("t%0d.winValid", i),  bus.winValid,  tbl[i].wv);
         chk($sformatf("t%0d.busy", i),      bus.busy,      tbl[i].busy);
         chk($sformatf("t%0d.frameDone", i), bus.frameDone, tbl[i].done);
         if (tbl[i].wen) chk($sformatf("t%0d.wrAddr", i), bus.wrAddr, tbl[i].waddr);
         if (tbl[i].ren) begin
            chk($sformatf("t%0d.rdAddr", i), bus.rdAddr, tbl[i].raddr);
            chk($sformatf("t%0d.topSel", i), bus.topSel, tbl[i].top);
            chk($sformatf("t%0d.midSel", i), bus.midSel, tbl[i].mid);
         end
         if (tbl[i].wv) begin
            chk($sformatf("t%0d.winCol", i), bus.winCol, tbl[i].wcol);
            chk($sformatf("t%0d.winRow", i), bus.winRow, tbl[i].wrow);
         end
      end
   endtask

   initial begin
      rst          = 1'b1;
      bus.start    = 1'b0;
      bus.pixValid = 1'b0;
      model_reset();

      // start, two rows of fill, then one streamed pixel
      add(1,0, 0,0,0,0, 0,0,0,0, 0,0,0, 0,0);
      for (int unsigned c = 0; c < 8; c++)
         add(0,1, 1,1,c/4,c%4, 0,0,0,0, 0,0,0, 1,0);
      add(0,1, 1,1,2,0, 1,0,0,1, 0,0,0, 1,0);
      // pixValid gaps 0,1,0,0,1
      add(0,0, 1,0,2,0, 0,0,0,0, 1,0,0, 1,0);
      add(0,1, 1,1,2,1, 1,1,0,1, 0,0,0, 1,0);
      add(0,0, 1,0,2,0, 0,0,0,0, 1,1,0, 1,0);
      add(0,0, 1,0,2,0, 0,0,0,0, 0,0,0, 1,0);
      add(0,1, 1,1,2,2, 1,2,0,1, 0,0,0, 1,0);
      add(0,1, 1,1,2,3, 1,3,0,1, 1,2,0, 1,0);
      // row 3: buffer rotation wraps to 0
      for (int unsigned c = 0; c < 4; c++)
         add(0,1, 1,1,0,c, 1,c,1,2, 1,(c == 0) ? 3 : c-1,(c == 0) ? 0 : 1, 1,0);
      // row 4, with a start in STREAM that must be ignored
      for (int unsigned c = 0; c < 4; c++)
         add((c == 1),1, 1,1,1,c, 1,c,2,0, 1,(c == 0) ? 3 : c-1,(c == 0) ? 1 : 2, 1,0);
      add(0,1, 0,0,2,0, 0,0,0,0, 1,3,2, 0,1);
      add(0,1, 0,0,2,0, 0,0,0,0, 0,0,0, 0,1);
      add(1,0, 0,0,2,0, 0,0,0,0, 0,0,0, 0,1);
      add(0,0, 1,0,0,0, 0,0,0,0, 0,0,0, 1,0);

      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_reset_outputs("por");

      // Reset mid-stream while a window is pending
      cycle(1'b1, 1'b0);
      repeat (9) cycle(1'b0, 1'b1);
      @(negedge clk);
      chk("pre_reset.winValid", bus.winValid, 1);
      rst = 1'b1;
      #1;
      check_reset_outputs("mid");
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      cycle(1'b0, 1'b1);
      cycle(1'b0, 1'b1);

      run_table();

      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_reset();

      for (int n = 0; n < 600; n++)
         cycle(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/line_buffer_scheduler.md
# line_buffer_scheduler

Sequences the rotating row buffers that feed the 3×3 neighbourhood kernel. It accepts a raster pixel stream with a valid/ready handshake and selects which row buffer is written at which address. Once two full rows are stored, it issues read addresses and top/middle buffer selects to the window mux, so the kernel gets one aligned column per accepted pixel. It sits between the pixel source and the row-buffer RAMs/window mux, in place of free-running counter control.

## Interface
- `LINE_LEN`, 256, pixels per row (≥2)
- `NUM_ROWS`, 256, rows per frame (≥3)
- `NUM_BUF`, 3, row buffers in rotation (≥3)
- `mainClk`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-high; all state and outputs to reset values
- `start`  in  1  begin a frame; honoured only in IDLE or DONE
- `pixValid`  in  1  source has a pixel
- `pixReady`  out  1  scheduler accepts; accept = pixValid && pixReady
- `wrEn`  out  1  write strobe to buffer `wrBuf`
- `wrBuf`  out  clog2(NUM_BUF)  buffer being written
- `wrAddr`  out  clog2(LINE_LEN)  column address of write
- `rdEn`  out  1  read strobe to all buffers
- `rdAddr`  out  clog2(LINE_LEN)  column address of read
- `topSel`  out  clog2(NUM_BUF)  buffer holding window top row
- `midSel`  out  clog2(NUM_BUF)  buffer holding window middle row
- `winValid`  out  1  window column valid at mux output
- `winCol`  out  clog2(LINE_LEN)  column of valid window
- `winRow`  out  clog2(NUM_ROWS)  top-row index of valid window
- `busy`  out  1  state is FILL or STREAM
- `frameDone`  out  1  level, high in DONE

## Operation
- States: IDLE → FILL → STREAM → DONE. DONE goes back to FILL on `start`.
- IDLE/DONE: pixReady=0. `start` clears col, row, and wrBuf to 0 and enters FILL.
- FILL/STREAM: pixReady=1. Each accept produces a same-cycle combinational write: wrEn=1, wrAddr=col, wrBuf current.
- col counts 0..LINE_LEN-1. At wrap: col→0, row+1, wrBuf=(wrBuf+1) mod NUM_BUF.
- FILL→STREAM: on the accept that completes row 1.
- STREAM: each accept also drives rdEn=1, rdAddr=col, topSel=(wrBuf+NUM_BUF-2) mod NUM_BUF, midSel=(wrBuf+NUM_BUF-1) mod NUM_BUF. The bottom row is the live pixel.
- STREAM→DONE: on the accept of col LINE_LEN-1 of row NUM_ROWS-1.
- No border padding. Windows cover rows 0..NUM_ROWS-3 and columns 0..LINE_LEN-1.
- `start` in FILL/STREAM is ignored. pixValid without pixReady is ignored and leaves the counters unchanged.
- Modular adds use the full index width and then a compare/subtract. No reliance on power-of-two NUM_BUF.

## Timing
- Reset values: pixReady, wrEn, rdEn, winValid, busy, frameDone = 0. wrBuf, wrAddr, rdAddr, topSel, midSel, winCol, winRow = 0. State is IDLE.
- wrEn, wrAddr, rdEn, rdAddr, topSel, midSel: combinational from state, counters, and pixValid. Zero-latency write.
- RAM read latency is 1. winValid, winCol, and winRow are registered one cycle after rdEn, with winRow = row-2 at the read.
- Gaps in pixValid produce matching gaps in winValid. No data is lost or duplicated.
- The final accept in STREAM still yields winValid on the next cycle, which is the first DONE cycle.
- `reset` mid-frame returns to IDLE immediately and drops any pending winValid.

## Structure
- Shared package: state encoding (IDLE/FILL/STREAM/DONE), the width function for clog2, and `RD_LAT`=1 as a named constant.
- One sub-module: `mod_counter`, a wrap counter with enable and a terminal-count output. It is instantiated for col, row, and wrBuf.

## Test plan
Benches run with LINE_LEN=4, NUM_ROWS=5, NUM_BUF=3.
- Reset asserted mid-stream, then released → all outputs at reset values; a pixValid with no start gets pixReady=0.
- start, then 8 accepts → wrBuf sequence 0,0,0,0,1,1,1,1 with wrAddr 0..3 twice; rdEn never high; busy=1; state STREAM after the 8th accept.
- 9th accept → wrBuf=2, rdEn=1, rdAddr=0, topSel=0, midSel=1. Next cycle: winValid=1, winRow=0, winCol=0.
- Row 3 (accepts 13–16) → wrBuf=0, topSel=1, midSel=2, winRow=1. Buffer rotation wraps.
- pixValid toggling 1,0,0,1 in STREAM → exactly two writes/reads. winValid pulses follow each accept by 1 cycle. col advances by 2.
- 20th accept → DONE: frameDone=1, pixReady=0, final winValid (winRow=2, winCol=3) one cycle later. Extra pixValid is ignored. A start in DONE → FILL with wrBuf=0.
